sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/sram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the SRAM port arbiter.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WAIT_CYC = 2;   // strobe width in cycles, legal 1..15

  // Bus phase of the single in-flight SRAM access.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    RECOVER
  } state_e;

  // One requester transaction at the default bus widths.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // High when port 1 wins a tie; port 0 is favoured out of reset.
  logic prio_1;

  // Grant decode: lone requester wins, ties go to the favoured port.
  // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_1 ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer update: the port just served loses the next tie.
  // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_1 <= 1'b0;
    end else if (accept) begin
      prio_1 <= grant[0];
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port front end for an asynchronous SRAM. One access at a time runs
// through SETUP -> ACTIVE (WAIT_CYC cycles) -> RECOVER; strobes are decoded
// from the phase so they drop on the same edge that resets or ends an access.
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYC = DEF_WAIT_CYC,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              sram_csb,
  output logic              sram_wrb,
  output logic [ADDR_W-1:0] sram_abus,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din
);

  // Counter value seen on the final ACTIVE cycle.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

  state_e            state;
  state_e            state_nxt;
  logic [3:0]        wait_cnt;
  logic [1:0]        grant;
  logic              accept;
  logic              last_active;

  logic              we_q;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Accept only from IDLE; reset masks the handshake immediately.
  always_comb begin
    accept      = (state == IDLE) && !rst && (grant != 2'b00);
    req0_ready  = accept && grant[0];
    req1_ready  = accept && grant[1];
    last_active = (state == ACTIVE) && (wait_cnt == LAST_CNT);
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACTIVE;
      ACTIVE:  if (last_active) state_nxt = RECOVER;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts ACTIVE cycles; cleared in every other phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (state == ACTIVE) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  // Latch the granted request; held until the next accept so the address
  // bus stays put from SETUP through RECOVER and idles at its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      port_q  <= grant[1];
      we_q    <= grant[1] ? req1_we    : req0_we;
      addr_q  <= grant[1] ? req1_addr  : req0_addr;
      wdata_q <= grant[1] ? req1_wdata : req0_wdata;
    end
  end

  // Per-port response data: sampled bus on reads, zero on writes, updated
  // on the last strobe cycle so it is ready for the RECOVER pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (last_active) begin
      if (port_q) begin
        rdata1_q <= we_q ? '0 : sram_din;
      end else begin
        rdata0_q <= we_q ? '0 : sram_din;
      end
    end
  end

  // SRAM pins and responses decoded from the phase. Write data keeps being
  // driven through RECOVER to give hold time after WRB rises.
  always_comb begin
    sram_csb   = rst || !((state == SETUP) || (state == ACTIVE));
    sram_wrb   = rst || !((state == ACTIVE) && we_q);
    sram_doe   = !rst && we_q && ((state == ACTIVE) || (state == RECOVER));
    sram_abus  = addr_q;
    sram_dout  = wdata_q;
    rsp0_valid = !rst && (state == RECOVER) && !port_q;
    rsp1_valid = !rst && (state == RECOVER) && port_q;
    rsp0_rdata = rdata0_q;
    rsp1_rdata = rdata1_q;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: WAIT_CYC=2 main instance plus a
// WAIT_CYC=1 instance for the short-strobe latency case.
module tb_sram_port_arbiter;
  import sram_ctrl_pkg::*;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Main instance (WAIT_CYC=2).
  logic        req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [11:0] req0_addr;
  logic [7:0]  req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [11:0] req1_addr;
  logic [7:0]  req1_wdata, rsp1_rdata;
  logic        sram_csb, sram_wrb, sram_doe;
  logic [11:0] sram_abus;
  logic [7:0]  sram_dout, sram_din;

  // Short-strobe instance (WAIT_CYC=1).
  logic        w1_req0_valid, w1_req0_ready, w1_req0_we, w1_rsp0_valid;
  logic [11:0] w1_req0_addr;
  logic [7:0]  w1_req0_wdata, w1_rsp0_rdata;
  logic        w1_req1_valid, w1_req1_ready, w1_req1_we, w1_rsp1_valid;
  logic [11:0] w1_req1_addr;
  logic [7:0]  w1_req1_wdata, w1_rsp1_rdata;
  logic        w1_sram_csb, w1_sram_wrb, w1_sram_doe;
  logic [11:0] w1_sram_abus;
  logic [7:0]  w1_sram_dout, w1_sram_din;

  sram_port_arbiter #(.WAIT_CYC(W), .ADDR_W(12), .DATA_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .sram_csb(sram_csb), .sram_wrb(sram_wrb), .sram_abus(sram_abus),
    .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din)
  );

  sram_port_arbiter #(.WAIT_CYC(1), .ADDR_W(12), .DATA_W(8)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .req0_valid(w1_req0_valid), .req0_ready(w1_req0_ready), .req0_we(w1_req0_we),
    .req0_addr(w1_req0_addr), .req0_wdata(w1_req0_wdata),
    .rsp0_valid(w1_rsp0_valid), .rsp0_rdata(w1_rsp0_rdata),
    .req1_valid(w1_req1_valid), .req1_ready(w1_req1_ready), .req1_we(w1_req1_we),
    .req1_addr(w1_req1_addr), .req1_wdata(w1_req1_wdata),
    .rsp1_valid(w1_rsp1_valid), .rsp1_rdata(w1_rsp1_rdata),
    .sram_csb(w1_sram_csb), .sram_wrb(w1_sram_wrb), .sram_abus(w1_sram_abus),
    .sram_dout(w1_sram_dout), .sram_doe(w1_sram_doe), .sram_din(w1_sram_din)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol watch on both instances every cycle: no write strobe without
  // chip select, and no bus drive while a read is in flight.
  logic mon_we    = 1'b0;
  logic w1_mon_we = 1'b0;
  always @(negedge clk) begin
    check("wrb_without_csb", {31'd0, (!sram_wrb && sram_csb)}, 32'd0);
    check("doe_on_read", {31'd0, (sram_doe && !mon_we)}, 32'd0);
    check("w1_wrb_without_csb", {31'd0, (!w1_sram_wrb && w1_sram_csb)}, 32'd0);
    check("w1_doe_on_read", {31'd0, (w1_sram_doe && !w1_mon_we)}, 32'd0);
    if (req0_ready) mon_we = req0_we;
    else if (req1_ready) mon_we = req1_we;
    if (w1_req0_ready) w1_mon_we = w1_req0_we;
    else if (w1_req1_ready) w1_mon_we = w1_req1_we;
  end

  function automatic logic [31:0] bus_vec();
    return {27'd0, sram_csb, sram_wrb, sram_doe, rsp1_valid, rsp0_valid};
  endfunction

  function automatic logic [31:0] w1_bus_vec();
    return {27'd0, w1_sram_csb, w1_sram_wrb, w1_sram_doe, w1_rsp1_valid, w1_rsp0_valid};
  endfunction

  task automatic start_txn(input int port, input sram_req_t r, input logic [7:0] din);
    sram_din = din;
    if (port == 0) begin
      req0_valid = 1'b1; req0_we = r.we; req0_addr = r.addr; req0_wdata = r.wdata;
    end else begin
      req1_valid = 1'b1; req1_we = r.we; req1_addr = r.addr; req1_wdata = r.wdata;
    end
  endtask

  // Called at the negedge of the accept cycle; walks the access to IDLE.
  task automatic finish_txn(input int port, input sram_req_t r, input logic [7:0] din);
    logic [31:0] exp_v;
    logic [31:0] rdy;
    logic [7:0]  rd;
    rdy = (port == 0) ? 32'd1 : 32'd2;
    check("ready", {30'd0, req1_ready, req0_ready}, rdy);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 1; c <= W + 3; c++) begin
      @(negedge clk);
      if (c == 1)          exp_v = 32'b01_000;
      else if (c <= W + 1) exp_v = {27'd0, 1'b0, !r.we, r.we, 2'b00};
      else if (c == W + 2) exp_v = {27'd0, 1'b1, 1'b1, r.we, (port == 1), (port == 0)};
      else                 exp_v = 32'b11_000;
      check($sformatf("bus_p%0d_c%0d", port, c), bus_vec(), exp_v);
      check($sformatf("abus_c%0d", c), 32'(sram_abus), 32'(r.addr));
      if (r.we && c >= 2 && c <= W + 2) check($sformatf("dout_c%0d", c), 32'(sram_dout), 32'(r.wdata));
      if (c >= W + 2) begin
        rd = (port == 0) ? rsp0_rdata : rsp1_rdata;
        check($sformatf("rdata_p%0d_c%0d", port, c), 32'(rd), r.we ? 32'd0 : 32'(din));
      end
    end
    step();
  endtask

  task automatic run_txn(input int port, input sram_req_t r, input logic [7:0] din);
    start_txn(port, r, din);
    @(negedge clk);
    finish_txn(port, r, din);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_rdy, exp_rsp;
    logic [31:0] exp_w1 [3];
    int k, ph;
    sram_req_t r;

    rst = 1'b1;
    {req0_valid, req0_we, req0_addr, req0_wdata} = '0;
    {req1_valid, req1_we, req1_addr, req1_wdata} = '0;
    sram_din = '0;
    {w1_req0_valid, w1_req0_we, w1_req0_addr, w1_req0_wdata} = '0;
    {w1_req1_valid, w1_req1_we, w1_req1_addr, w1_req1_wdata} = '0;
    w1_sram_din = '0;

    // Reset: outputs idle, ready masked even with a request pending.
    req0_valid = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst_bus", bus_vec(), 32'b11_000);
    check("rst_abus", 32'(sram_abus), 32'd0);
    check("rst_dout", 32'(sram_dout), 32'd0);
    check("rst_rdata", {16'd0, rsp1_rdata, rsp0_rdata}, 32'd0);
    step();
    rst = 1'b0;
    req0_valid = 1'b0;

    // Both ports valid continuously: port0 writes, port1 reads.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h010; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h020; req1_wdata = 8'h00;
    sram_din = 8'h66;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k  = i / 5;
      ph = i % 5;
      exp_rdy = (ph == 0) ? ((k % 2 == 0) ? 32'd1 : 32'd2) : 32'd0;
      exp_rsp = (ph == 4) ? ((k % 2 == 0) ? 32'd1 : 32'd2) : 32'd0;
      check($sformatf("arb_ready_i%0d", i), {30'd0, req1_ready, req0_ready}, exp_rdy);
      check($sformatf("arb_rsp_i%0d", i), {30'd0, rsp1_valid, rsp0_valid}, exp_rsp);
    end
    check("arb_rdata1", 32'(rsp1_rdata), 32'h66);
    check("arb_rdata0", 32'(rsp0_rdata), 32'h00);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single write then read-back of the same location.
    r = '{we: 1'b1, addr: 12'h0A5, wdata: 8'h3C}; run_txn(0, r, 8'h00);
    r = '{we: 1'b0, addr: 12'h0A5, wdata: 8'h00}; run_txn(1, r, 8'h3C);

    // Address extremes with extreme data.
    r = '{we: 1'b1, addr: 12'h000, wdata: 8'h00}; run_txn(0, r, 8'h00);
    r = '{we: 1'b1, addr: 12'hFFF, wdata: 8'hFF}; run_txn(1, r, 8'h00);
    r = '{we: 1'b0, addr: 12'hFFF, wdata: 8'h00}; run_txn(1, r, 8'hFF);
    r = '{we: 1'b0, addr: 12'h000, wdata: 8'h00}; run_txn(1, r, 8'h00);
    r = '{we: 1'b0, addr: 12'hFFF, wdata: 8'h00}; run_txn(0, r, 8'hFF);

    // Reset in the first strobe cycle of a write aborts it.
    r = '{we: 1'b1, addr: 12'h2B0, wdata: 8'h99};
    start_txn(0, r, 8'h00);
    @(negedge clk);
    check("abort_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("abort_bus_in_rst", bus_vec(), 32'b11_000);
    step();
    rst = 1'b0;
    r = '{we: 1'b0, addr: 12'h2B0, wdata: 8'h00};
    start_txn(1, r, 8'h44);
    @(negedge clk);
    check("abort_bus_after", bus_vec(), 32'b11_000);
    check("abort_abus", 32'(sram_abus), 32'd0);
    check("abort_dout", 32'(sram_dout), 32'd0);
    finish_txn(1, r, 8'h44);

    // WAIT_CYC=1: read then write, response three cycles after accept.
    w1_sram_din = 8'h5A;
    w1_req0_valid = 1'b1; w1_req0_we = 1'b0; w1_req0_addr = 12'h123;
    @(negedge clk);
    check("w1_rd_ready", {30'd0, w1_req1_ready, w1_req0_ready}, 32'd1);
    step();
    w1_req0_valid = 1'b0;
    exp_w1[0] = 32'b01_000; exp_w1[1] = 32'b01_000; exp_w1[2] = 32'b11_001;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("w1_rd_bus_c%0d", c), w1_bus_vec(), exp_w1[c-1]);
      check($sformatf("w1_rd_abus_c%0d", c), 32'(w1_sram_abus), 32'h123);
    end
    check("w1_rd_rdata", 32'(w1_rsp0_rdata), 32'h5A);
    step();
    w1_req1_valid = 1'b1; w1_req1_we = 1'b1; w1_req1_addr = 12'h456; w1_req1_wdata = 8'h77;
    @(negedge clk);
    check("w1_wr_ready", {30'd0, w1_req1_ready, w1_req0_ready}, 32'd2);
    step();
    w1_req1_valid = 1'b0;
    exp_w1[0] = 32'b01_000; exp_w1[1] = 32'b00_100; exp_w1[2] = 32'b11_110;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("w1_wr_bus_c%0d", c), w1_bus_vec(), exp_w1[c-1]);
    end
    check("w1_wr_dout", 32'(w1_sram_dout), 32'h77);
    check("w1_wr_rdata", 32'(w1_rsp1_rdata), 32'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
